mac_requant_drain: RTL and testbench

Downstream stage of the 24-bit-accumulator MAC unit. Consumes the MAC's accumulator/valid pulse stream, adds a per-channel bias, applies a rounding arithmetic right shift, saturates to a signed 8-bit activation, and applies an optional ReLU. Results are buffered in a small FIFO behind a valid/ready output, so the non-stallable MAC stream can be drained by a back-pressuring consumer such as a writeback or next-layer feeder.

---
 rtl/mac_requant_drain_if.sv | 26 ++
 rtl/mac_requant_drain.sv | 135 +++++++++++++
 tb/tb_mac_requant_drain.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_requant_drain_if.sv
// Stream bundle between the MAC accumulator output, the requantiser and its consumer.
// The master drives the samples and out_ready; the slave returns the requantised results.
interface mac_requant_drain_if #(
  parameter int ACCUM_WIDTH = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
);
  logic [ACCUM_WIDTH-1:0] accum_in;
  logic                   valid_in;
  logic [ACCUM_WIDTH-1:0] bias_in;
  logic [SHIFT_WIDTH-1:0] shift_amt;
  logic                   relu_en;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output accum_in, valid_in, bias_in, shift_amt, relu_en, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  accum_in, valid_in, bias_in, shift_amt, relu_en, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/mac_requant_drain.sv
// Requantises the MAC accumulator stream (bias, rounding shift, saturate, ReLU) and buffers
// the results in a small FIFO so a back-pressuring consumer can drain the non-stallable stream.
module mac_requant_drain #(
  parameter int ACCUM_WIDTH = 24,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  mac_requant_drain_if.slave            bus,
  input  logic                          flush,
  input  logic                          err_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = ACCUM_WIDTH + 1;
  localparam int RW = ACCUM_WIDTH + 2;
  localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(ACCUM_WIDTH - 1);
  localparam logic signed [RW-1:0]   SAT_MAX   = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0]   SAT_MIN   = ~SAT_MAX;

  logic                    s1_valid;
  logic signed [SW-1:0]    s1_sum;
  logic [SHIFT_WIDTH-1:0]  s1_shift;
  logic                    s1_relu;
  logic signed [SW-1:0]    sum_c;

  logic                    s2_valid;
  logic [OUT_WIDTH-1:0]    s2_data;
  logic signed [RW-1:0]    sum_ext;
  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    shifted;
  logic signed [RW-1:0]    sat;
  logic [OUT_WIDTH-1:0]    res_c;

  logic [OUT_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             level;
  logic [PW:0]             level_nxt;
  logic                    out_valid_q;
  logic                    full;
  logic                    pop;
  logic                    do_push;
  logic                    drop;

  // Sum is one bit wider than the operands so bias addition can never wrap.
  assign sum_c = $signed({bus.accum_in[ACCUM_WIDTH-1], bus.accum_in})
               + $signed({bus.bias_in[ACCUM_WIDTH-1], bus.bias_in});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_valid <= bus.valid_in & ~flush;
      if (bus.valid_in) begin
        s1_sum   <= sum_c;
        s1_shift <= (bus.shift_amt > MAX_SHIFT) ? MAX_SHIFT : bus.shift_amt;
        s1_relu  <= bus.relu_en;
      end
    end
  end

  // Rounding constant is 2^(n-1), which collapses to zero for n = 0.
  always_comb begin
    sum_ext = {s1_sum[SW-1], s1_sum};
    rnd     = (RW'(1) << s1_shift) >> 1;
    shifted = (sum_ext + rnd) >>> s1_shift;
    if (shifted > SAT_MAX)      sat = SAT_MAX;
    else if (shifted < SAT_MIN) sat = SAT_MIN;
    else                        sat = shifted;
    if (s1_relu && sat[RW-1])   sat = '0;
    res_c = sat[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid & ~flush;
      if (s1_valid) s2_data <= res_c;
    end
  end

  // A pop frees the full slot in the same cycle, so push-while-full with pop is not a drop.
  assign full    = (level == (PW+1)'(FIFO_DEPTH));
  assign pop     = out_valid_q & bus.out_ready;
  assign do_push = s2_valid & (~full | pop);
  assign drop    = s2_valid & full & ~pop & ~flush;

  always_comb begin
    level_nxt = level;
    if (do_push && !pop)      level_nxt = level + 1'b1;
    else if (pop && !do_push) level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level       <= level_nxt;
      out_valid_q <= (level_nxt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow_err <= 1'b0;
    else if (drop)      overflow_err <= 1'b1;
    else if (err_clear) overflow_err <= 1'b0;
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = out_valid_q;
  assign fifo_level    = level;
endmodule

// File: tb/tb_mac_requant_drain.sv
// Bench for mac_requant_drain: directed vectors plus a random phase, all checked against a
// queue-based reference model of the requantiser and its output buffer.
module tb_mac_requant_drain;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       err_clear = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_requant_drain_if bus ();

  mac_requant_drain dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .err_clear    (err_clear),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input logic [23:0] a, input logic [23:0] b,
                                       input logic [4:0] s, input logic relu);
    longint sum, r;
    int n;
    sum = longint'($signed(a)) + longint'($signed(b));
    n   = (s > 23) ? 23 : int'(s);
    if (n == 0) r = sum;
    else        r = (sum + (longint'(1) << (n - 1))) >>> n;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return r[7:0];
  endfunction

  // Reference: two-slot delay line of computed results feeding a 4-entry queue.
  logic [7:0] mq[$];
  logic       p1v = 1'b0, p2v = 1'b0, merr = 1'b0;
  logic [7:0] p1d = '0, p2d = '0;

  initial begin
    forever begin
      logic m_pop, m_drop;
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        p1v = 1'b0;
        p2v = 1'b0;
        merr = 1'b0;
      end else begin
        m_pop  = (mq.size() > 0) && bus.out_ready;
        m_drop = 1'b0;
        if (flush) begin
          mq.delete();
          p1v = 1'b0;
          p2v = 1'b0;
        end else begin
          if (m_pop) void'(mq.pop_front());
          if (p2v) begin
            if (mq.size() < 4) mq.push_back(p2d);
            else               m_drop = 1'b1;
          end
          p2v = p1v;
          p2d = p1d;
          p1v = bus.valid_in;
          p1d = ref_q(bus.accum_in, bus.bias_in, bus.shift_amt, bus.relu_en);
        end
        if (m_drop)         merr = 1'b1;
        else if (err_clear) merr = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("mon_valid", bus.out_valid, mq.size() != 0);
        chk("mon_level", fifo_level, mq.size());
        chk("mon_err", overflow_err, merr);
        if (mq.size() != 0) chk("mon_data", bus.out_data, mq[0]);
      end
    end
  end

  task automatic drive(input logic [23:0] a, input logic [23:0] b,
                       input logic [4:0] s, input logic r);
    bus.valid_in  = 1'b1;
    bus.accum_in  = a;
    bus.bias_in   = b;
    bus.shift_amt = s;
    bus.relu_en   = r;
  endtask

  task automatic one(input string tag, input logic [23:0] a, input logic [23:0] b,
                     input logic [4:0] s, input logic r, input logic [7:0] exp);
    @(negedge clk);
    drive(a, b, s, r);
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk(tag, bus.out_data, exp);
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.accum_in  = '0;
    bus.bias_in   = '0;
    bus.shift_amt = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_err", overflow_err, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    one("basic", 24'h000064, 24'h0, 5'd0, 1'b0, 8'h64);

    @(negedge clk); drive(24'd1, 24'd0, 5'd0, 1'b0);
    @(negedge clk); drive(24'd2, 24'd0, 5'd0, 1'b0);
    @(negedge clk); drive(24'd3, 24'd0, 5'd0, 1'b0);
    @(negedge clk); bus.valid_in = 1'b0; chk("b2b_1", bus.out_data, 8'd1);
    @(negedge clk); chk("b2b_2", bus.out_data, 8'd2);
    @(negedge clk); chk("b2b_3", bus.out_data, 8'd3);

    one("sat_pos",  24'd300,    24'h0,      5'd0,  1'b0, 8'h7F);
    one("sat_neg",  24'hFFFED4, 24'h0,      5'd0,  1'b0, 8'h80);
    one("relu_neg", 24'hFFFED4, 24'h0,      5'd0,  1'b1, 8'h00);
    one("no_wrap",  24'h7FFFFF, 24'h7FFFFF, 5'd0,  1'b0, 8'h7F);
    one("rnd_180",  24'd180,    24'h0,      5'd2,  1'b0, 8'h2D);
    one("rnd_182",  24'd182,    24'h0,      5'd2,  1'b0, 8'd46);
    one("rnd_m6",   24'hFFFFFA, 24'h0,      5'd2,  1'b0, 8'hFF);
    one("rnd_m7",   24'hFFFFF9, 24'h0,      5'd1,  1'b0, 8'hFD);
    // Clamped shift of 23: exactly one half rounds up, just below one half rounds to zero.
    one("clamp_hi", 24'h400000, 24'h0,      5'd31, 1'b0, 8'h01);
    one("clamp_lo", 24'h3FFFFF, 24'h0,      5'd31, 1'b0, 8'h00);
    one("bias",     24'd1000,   24'hFFFC7C, 5'd0,  1'b0, 8'h64);

    // Backpressure and overflow.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(24'(i), 24'd0, 5'd0, 1'b0);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    chk("ovf_level4", fifo_level, 4);
    chk("ovf_err_pre", overflow_err, 1'b0);
    @(negedge clk);
    chk("ovf_err_set", overflow_err, 1'b1);
    chk("ovf_level_hold", fifo_level, 4);
    @(negedge clk);
    chk("ovf_level_hold2", fifo_level, 4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", bus.out_data, 8'(i));
      @(negedge clk);
    end
    chk("drain_level0", fifo_level, 0);

    // Flush coinciding with a pending push; error flag must survive.
    bus.out_ready = 1'b0;
    drive(24'd7, 24'd0, 5'd0, 1'b0);
    @(negedge clk); drive(24'd8, 24'd0, 5'd0, 1'b0);
    @(negedge clk); drive(24'd9, 24'd0, 5'd0, 1'b0);
    @(negedge clk); bus.valid_in = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_level", fifo_level, 0);
    chk("flush_err_kept", overflow_err, 1'b1);
    repeat (3) @(negedge clk);
    chk("flush_no_stale", bus.out_valid, 1'b0);

    err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk("err_clear", overflow_err, 1'b0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 10; i <= 14; i++) begin
      drive(24'(i), 24'd0, 5'd0, 1'b0);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("full_before", fifo_level, 4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("full_pp_level", fifo_level, 4);
    chk("full_pp_err", overflow_err, 1'b0);
    chk("full_pp_head", bus.out_data, 8'd11);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_pp_drained", fifo_level, 0);

    // Asynchronous reset mid-operation.
    bus.out_ready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      drive(24'(i), 24'd0, 5'd0, 1'b0);
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_level", fifo_level, 3);
    drive(24'd23, 24'd0, 5'd0, 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_level", fifo_level, 0);
    chk("arst_data", bus.out_data, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 1'b0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      bus.valid_in  = ($urandom_range(0, 3) != 0);
      bus.accum_in  = $urandom_range(0, 1) ? 24'($urandom_range(0, 2000) - 1000) : 24'($urandom);
      bus.bias_in   = $urandom_range(0, 1) ? 24'($urandom_range(0, 600) - 300) : 24'($urandom);
      bus.shift_amt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 6));
      bus.relu_en   = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 49) == 0);
      err_clear     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    bus.valid_in  = 1'b0;
    flush         = 1'b0;
    err_clear     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("final_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
